// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the
// baud divider calculation used by both the RX and TX sides.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned SAMPLE_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W       = $clog2(DATA_BITS);
  localparam int unsigned MID_SAMPLE  = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_SAMPLE = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick; never below one so the divider always ticks.
  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    int unsigned div;
    div = clk_hz / (baud * OVERSAMPLE);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider with synchronous clear,
// one-clock tick each time the divider wraps.
module uart_baud_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = (cnt == CNT_W'(TICK_DIV - 1));
  // A clear restarts the bit timing, so it also masks a coincident wrap.
  assign tick_c = wrap_c && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (wrap_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 asynchronous receiver with a one-byte holding register, ready flag,
// read strobe and sticky framing/overrun error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned TICK_DIV = calc_tick_div(CLK_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  input  logic                 UART_rd,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 RE,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  logic                 rx_m;
  logic                 rx_s;
  rx_state_t            state;
  logic [SAMPLE_W-1:0]  sample_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic start_c;
  logic tick_c;
  logic mid_start_c;
  logic last_sample_c;
  logic deliver_c;
  logic stop_bad_c;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
    end
  end

  assign start_c = (state == IDLE) && !rx_s;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_c),
    .tick_c (tick_c)
  );

  assign mid_start_c   = tick_c && (sample_cnt == SAMPLE_W'(MID_SAMPLE));
  assign last_sample_c = tick_c && (sample_cnt == SAMPLE_W'(LAST_SAMPLE));
  assign deliver_c     = (state == STOP) && last_sample_c && rx_s;
  assign stop_bad_c    = (state == STOP) && last_sample_c && !rx_s;

  // Frame sequencing: start qualification, data shift, stop check, break wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            sample_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (mid_start_c) begin
            if (!rx_s) begin
              state      <= DATA;
              sample_cnt <= '0;
              bit_cnt    <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tick_c) begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
        DATA: begin
          if (last_sample_c) begin
            sample_cnt <= '0;
            shreg      <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt    <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end
          end else if (tick_c) begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
        STOP: begin
          if (last_sample_c) begin
            sample_cnt <= '0;
            state      <= rx_s ? IDLE : BREAK;
            busy       <= !rx_s;
          end else if (tick_c) begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register and flags; error sets are written last so they win over err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout      <= '0;
      RE        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (stop_bad_c) begin
        frame_err <= 1'b1;
      end
      if (deliver_c) begin
        if (!RE || UART_rd) begin
          dout <= shreg;
          RE   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (UART_rd) begin
        RE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench: ideal 8N1 driver, transaction-level expectation model
// and a scoreboard monitor that checks each byte as RE rises.
module tb_uart_rx_core;

  localparam int unsigned CLK_HZ   = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic       UART_rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       RE;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .UART_rd   (UART_rd),
    .err_clr   (err_clr),
    .dout      (dout),
    .RE        (RE),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Host-visible model: what the processor should see after each frame/read/clear.
  bit         m_re = 1'b0;
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;
  logic [7:0] m_dout = 8'h00;
  int         frame_t0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else if (!m_re) begin
      exp_q.push_back('{b, frame_t0});
      m_re   = 1'b1;
      m_dout = b;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Model is updated mid stop bit, just before the receiver can raise RE.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    frame_t0 = cyc;
    RxD = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick(BIT_CLKS);
    end
    RxD = stop_ok;
    tick(6);
    model_frame(b, stop_ok);
    tick(BIT_CLKS - 6);
  endtask

  task automatic do_read();
    UART_rd = 1'b1;
    tick(1);
    UART_rd = 1'b0;
    m_re = 1'b0;
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic check_state(input string tag, input bit exp_busy);
    @(negedge clk);
    chk({tag, "_re"}, 32'(RE), 32'(m_re));
    chk({tag, "_dout"}, 32'(dout), 32'(m_dout));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    tick(1);
  endtask

  // Scoreboard monitor: every rising RE must match the oldest expected byte.
  initial begin : monitor
    exp_t e;
    int   lat;
    bit   re_q;
    re_q = 1'b0;
    forever begin
      @(negedge clk);
      if (RE === 1'b1 && !re_q) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_re: got delivery of 0x%0h required none", dout);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(dout), 32'(e.data));
          lat = cyc - e.t0;
          n_checks++;
          if (lat < 152 || lat > 156) begin
            n_err++;
            $display("FAIL rx_latency: got %0d clk required 152..156", lat);
          end
        end
      end
      re_q = (RE === 1'b1);
    end
  end

  initial begin : watchdog
    repeat (50_000) @(posedge clk);
    $display("FAIL watchdog: got no finish within 50000 clk required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    bit         ok;

    tick(3);
    reset = 1'b0;
    check_state("reset", 1'b0);

    // Single byte, then read.
    tick(5);
    send_frame(8'hA5, 1'b1);
    check_state("t1_rx", 1'b0);
    do_read();
    check_state("t1_rd", 1'b0);

    // Back-to-back frames with a read early in the second frame.
    send_frame(8'h3C, 1'b1);
    fork
      begin
        tick(1);
        do_read();
      end
    join_none
    send_frame(8'hC3, 1'b1);
    do_read();
    check_state("t2", 1'b0);

    // Unread byte followed by another: overrun, old byte kept.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_state("t3_ovr", 1'b0);
    do_clr();
    check_state("t3_clr", 1'b0);
    do_read();

    // Short low glitch on the idle line.
    RxD = 1'b0;
    tick(5);
    RxD = 1'b1;
    @(negedge clk);
    chk("t4_busy_during", 32'(busy), 32'd1);
    tick(30);
    check_state("t4_after", 1'b0);

    // Bad stop bit then line held low: one error, cleared error stays clear.
    send_frame(8'hFF, 1'b0);
    tick(10);
    check_state("t5_ferr", 1'b1);
    do_clr();
    tick(40);
    check_state("t5_hold", 1'b1);
    tick(45);
    RxD = 1'b1;
    tick(10);
    check_state("t5_rel", 1'b0);
    send_frame(8'h5A, 1'b1);
    check_state("t5_good", 1'b0);

    // Reset during data bit 4 of a frame.
    b = 8'($urandom());
    RxD = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      tick(BIT_CLKS);
    end
    RxD = b[4];
    tick(4);
    reset = 1'b1;
    RxD   = 1'b1;
    tick(1);
    reset  = 1'b0;
    m_re   = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_dout = 8'h00;
    check_state("t6_rst", 1'b0);
    chk("t6_no_pending", 32'(exp_q.size()), 32'd0);
    tick(20);
    send_frame(8'h81, 1'b1);
    check_state("t6_rx", 1'b0);
    do_read();

    // Randomized traffic: bytes, occasional bad stop, skipped reads and clears.
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom());
      ok = ($urandom_range(7) != 0);
      send_frame(b, ok);
      if (!ok) begin
        RxD = 1'b1;
        tick(4 + int'($urandom_range(6)));
      end else begin
        tick(int'($urandom_range(8)));
      end
      if ($urandom_range(3) != 0) do_read();
      if ($urandom_range(5) == 0) do_clr();
      check_state("rnd", 1'b0);
    end

    tick(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
